// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared widths and FSM state encoding for the icache refill engine
package icache_refill_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int ICACHE_BLK_WIDTH = 512;
  localparam int ICACHE_OFFSET_RANGE = 6;
  typedef enum logic [1:0] {IDLE, REQ, READ, DONE} state_t;
endpackage

// File: rtl/icache_refill.sv
// icache_refill: on a miss, arbitrates for the byte-wide RAM, streams one line little-endian and strobes it into the icache
// ports: clk/rst_in (async active-low); miss_in/if_ain/flush_in from fetch; ram_req/ram_gnt/ram_a/ram_wr/ram_din to the
// RAM arbiter; fill_en/fill_a/fill_d to the icache fill port (mem_in_en/mem_ain/mem_din)
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int BLK_BYTES = ICACHE_BLK_WIDTH / 8,
  parameter int BLK_BITS = 8 * BLK_BYTES,
  parameter int OFF_W = $clog2(BLK_BYTES)
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                miss_in,
  input  logic [ADDR_W-1:0]   if_ain,
  input  logic                flush_in,
  output logic                ram_req,
  input  logic                ram_gnt,
  output logic [ADDR_W-1:0]   ram_a,
  output logic                ram_wr,
  input  logic [7:0]          ram_din,
  output logic                fill_en,
  output logic [ADDR_W-1:0]   fill_a,
  output logic [BLK_BITS-1:0] fill_d
);
  localparam logic [OFF_W:0] LAST = (OFF_W + 1)'(BLK_BYTES - 1);
  localparam logic [OFF_W:0] FULL = (OFF_W + 1)'(BLK_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLK_BYTES - 1);
  state_t state, nxt;
  logic [OFF_W:0] issue_cnt, cap_cnt, off;
  logic cap_valid, issuing;
  logic [ADDR_W-1:0] base;
  assign ram_wr = 1'b0;
  assign fill_a = base;
  // issue_cnt runs one past the last byte to mark "all issued"; the address stays on the last byte
  assign issuing = state == READ && issue_cnt != FULL;
  assign off = issue_cnt == FULL ? LAST : issue_cnt;
  assign ram_a = state == READ ? base + ADDR_W'(off) : '0;
  always_comb begin
    nxt = state == IDLE ? (miss_in && !flush_in ? REQ : IDLE)
        : state == DONE ? IDLE
        : flush_in ? IDLE
        : state == REQ ? (ram_gnt ? READ : REQ)
        : (cap_valid && cap_cnt == LAST ? DONE : READ);
  end
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      ram_req <= 1'b0;
      fill_en <= 1'b0;
      base <= '0;
      fill_d <= '0;
      issue_cnt <= '0;
      cap_cnt <= '0;
      cap_valid <= 1'b0;
    end else begin
      state <= nxt;
      ram_req <= nxt == REQ || nxt == READ;
      fill_en <= nxt == DONE;
      cap_valid <= issuing;
      if (state == IDLE && miss_in && !flush_in) base <= if_ain & ~OFF_MASK;
      if (state == REQ && ram_gnt) begin
        issue_cnt <= '0;
        cap_cnt <= '0;
      end
      if (issuing) issue_cnt <= issue_cnt + 1'b1;
      if (state == READ && cap_valid) begin
        fill_d[8*cap_cnt[OFF_W-1:0] +: 8] <= ram_din;
        cap_cnt <= cap_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed self-checking bench for icache_refill with a byte RAM model
module tb_icache_refill;
  logic clk = 0, rst_in = 0, miss_in = 0, flush_in = 0, ram_gnt = 0;
  logic [31:0] if_ain = 0;
  logic ram_req, ram_wr, fill_en;
  logic [31:0] ram_a, fill_a;
  logic [7:0] ram_din = 0;
  logic [511:0] fill_d;
  int vecs = 0, errs = 0;
  logic req_log [200];
  logic [31:0] a_log [200];
  int nfill, fill_cyc;
  logic [31:0] got_fa;
  logic [511:0] got_fd;

  icache_refill dut (
    .clk(clk), .rst_in(rst_in), .miss_in(miss_in), .if_ain(if_ain), .flush_in(flush_in),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din),
    .fill_en(fill_en), .fill_a(fill_a), .fill_d(fill_d)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [31:0] a);
    return a[7:0] ^ {a[13:8], a[15:14]} ^ 8'hA5;
  endfunction

  function automatic logic [511:0] line(input logic [31:0] a);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[8*i +: 8] = mem(a + 32'(i));
    return l;
  endfunction

  always @(posedge clk) ram_din <= mem(ram_a);

  // cycle 0 is the cycle in which the miss is sampled; logs cover cycles 1..n-1
  task automatic run(input bit do_miss, input logic [31:0] addr, input int gd, input int fl, input int n);
    @(posedge clk); #1;
    if_ain = addr;
    miss_in = do_miss;
    ram_gnt = gd == 0;
    nfill = 0;
    fill_cyc = -1;
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      miss_in = 0;
      ram_gnt = c > gd;
      flush_in = c == fl;
      @(negedge clk);
      req_log[c] = ram_req;
      a_log[c] = ram_a;
      if (fill_en) begin
        nfill++;
        fill_cyc = c;
        got_fa = fill_a;
        got_fd = fill_d;
      end
    end
    @(posedge clk); #1;
    flush_in = 0;
  endtask

  task automatic test_reset;
    rst_in = 0;
    #2;
    vecs++; if (ram_req !== 1'b0) begin errs++; $display("FAIL reset ram_req got %b exp 0", ram_req); end
    vecs++; if (ram_a !== 32'h0) begin errs++; $display("FAIL reset ram_a got %h exp 0", ram_a); end
    vecs++; if (ram_wr !== 1'b0) begin errs++; $display("FAIL reset ram_wr got %b exp 0", ram_wr); end
    vecs++; if (fill_en !== 1'b0) begin errs++; $display("FAIL reset fill_en got %b exp 0", fill_en); end
    vecs++; if (fill_a !== 32'h0) begin errs++; $display("FAIL reset fill_a got %h exp 0", fill_a); end
    vecs++; if (fill_d !== '0) begin errs++; $display("FAIL reset fill_d got nonzero exp 0"); end
    @(posedge clk); #1;
    rst_in = 1;
  endtask

  task automatic test_basic;
    run(1, 32'h0000_1234, 0, -1, 80);
    vecs++; if (req_log[1] !== 1'b1) begin errs++; $display("FAIL basic req_c1 got %b exp 1", req_log[1]); end
    vecs++; if (a_log[1] !== 32'h0) begin errs++; $display("FAIL basic ram_a_req got %h exp 0", a_log[1]); end
    for (int c = 2; c <= 65; c++) begin
      vecs++;
      if (a_log[c] !== 32'h1200 + 32'(c - 2)) begin errs++; $display("FAIL basic ram_a c%0d got %h exp %h", c, a_log[c], 32'h1200 + 32'(c - 2)); end
    end
    vecs++; if (nfill !== 1) begin errs++; $display("FAIL basic nfill got %0d exp 1", nfill); end
    vecs++; if (fill_cyc !== 67) begin errs++; $display("FAIL basic fill_cyc got %0d exp 67", fill_cyc); end
    vecs++; if (got_fa !== 32'h1200) begin errs++; $display("FAIL basic fill_a got %h exp 1200", got_fa); end
    vecs++; if (got_fd[7:0] !== mem(32'h1200)) begin errs++; $display("FAIL basic byte0 got %h exp %h", got_fd[7:0], mem(32'h1200)); end
    vecs++; if (got_fd[511:504] !== mem(32'h123F)) begin errs++; $display("FAIL basic byte63 got %h exp %h", got_fd[511:504], mem(32'h123F)); end
    vecs++; if (got_fd !== line(32'h1200)) begin errs++; $display("FAIL basic line got %h exp %h", got_fd, line(32'h1200)); end
    vecs++; if (req_log[67] !== 1'b0) begin errs++; $display("FAIL basic req_done got %b exp 0", req_log[67]); end
  endtask

  task automatic test_grant_delay;
    run(1, 32'h0000_3456, 5, -1, 85);
    for (int c = 1; c <= 6; c++) begin
      vecs++; if (req_log[c] !== 1'b1) begin errs++; $display("FAIL gdly req c%0d got %b exp 1", c, req_log[c]); end
      vecs++; if (a_log[c] !== 32'h0) begin errs++; $display("FAIL gdly ram_a c%0d got %h exp 0", c, a_log[c]); end
    end
    vecs++; if (a_log[7] !== 32'h3440) begin errs++; $display("FAIL gdly first_a got %h exp 3440", a_log[7]); end
    vecs++; if (nfill !== 1) begin errs++; $display("FAIL gdly nfill got %0d exp 1", nfill); end
    vecs++; if (fill_cyc !== 72) begin errs++; $display("FAIL gdly fill_cyc got %0d exp 72", fill_cyc); end
    vecs++; if (got_fd !== line(32'h3440)) begin errs++; $display("FAIL gdly line got %h exp %h", got_fd, line(32'h3440)); end
  endtask

  task automatic test_flush;
    run(1, 32'h0000_5678, 0, 23, 80);
    vecs++; if (req_log[23] !== 1'b1) begin errs++; $display("FAIL flush req_at got %b exp 1", req_log[23]); end
    vecs++; if (req_log[24] !== 1'b0) begin errs++; $display("FAIL flush req_after got %b exp 0", req_log[24]); end
    vecs++; if (a_log[24] !== 32'h0) begin errs++; $display("FAIL flush ram_a_after got %h exp 0", a_log[24]); end
    vecs++; if (nfill !== 0) begin errs++; $display("FAIL flush nfill got %0d exp 0", nfill); end
    run(1, 32'h0000_2000, 0, -1, 80);
    vecs++; if (nfill !== 1) begin errs++; $display("FAIL flush2 nfill got %0d exp 1", nfill); end
    vecs++; if (fill_cyc !== 67) begin errs++; $display("FAIL flush2 fill_cyc got %0d exp 67", fill_cyc); end
    vecs++; if (got_fa !== 32'h2000) begin errs++; $display("FAIL flush2 fill_a got %h exp 2000", got_fa); end
    vecs++; if (got_fd !== line(32'h2000)) begin errs++; $display("FAIL flush2 line got %h exp %h", got_fd, line(32'h2000)); end
  endtask

  task automatic test_flush_done;
    run(1, 32'h0000_7780, 0, 67, 75);
    vecs++; if (nfill !== 1) begin errs++; $display("FAIL flushdone nfill got %0d exp 1", nfill); end
    vecs++; if (fill_cyc !== 67) begin errs++; $display("FAIL flushdone fill_cyc got %0d exp 67", fill_cyc); end
    vecs++; if (got_fa !== 32'h7780) begin errs++; $display("FAIL flushdone fill_a got %h exp 7780", got_fa); end
    vecs++; if (got_fd !== line(32'h7780)) begin errs++; $display("FAIL flushdone line got %h exp %h", got_fd, line(32'h7780)); end
  endtask

  task automatic test_reset_mid;
    int bad;
    run(1, 32'h0000_9000, 0, -1, 30);
    vecs++; if (ram_req !== 1'b1) begin errs++; $display("FAIL rstmid pre_req got %b exp 1", ram_req); end
    #3;
    rst_in = 0;
    #1;
    vecs++; if (ram_req !== 1'b0) begin errs++; $display("FAIL rstmid ram_req got %b exp 0", ram_req); end
    vecs++; if (ram_a !== 32'h0) begin errs++; $display("FAIL rstmid ram_a got %h exp 0", ram_a); end
    vecs++; if (fill_en !== 1'b0) begin errs++; $display("FAIL rstmid fill_en got %b exp 0", fill_en); end
    vecs++; if (fill_a !== 32'h0) begin errs++; $display("FAIL rstmid fill_a got %h exp 0", fill_a); end
    vecs++; if (fill_d !== '0) begin errs++; $display("FAIL rstmid fill_d got nonzero exp 0"); end
    @(posedge clk); #1;
    rst_in = 1;
    run(0, 32'h0000_9000, 0, -1, 80);
    bad = 0;
    for (int c = 1; c < 80; c++) if (req_log[c] !== 1'b0 || a_log[c] !== 32'h0) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL rstmid idle_busy got %0d cycles exp 0", bad); end
    vecs++; if (nfill !== 0) begin errs++; $display("FAIL rstmid nfill got %0d exp 0", nfill); end
  endtask

  task automatic test_back_to_back;
    int n1;
    logic [31:0] fa1;
    logic [511:0] fd1;
    logic rq1;
    run(1, 32'h0000_0040, 0, -1, 68);
    n1 = nfill; fa1 = got_fa; fd1 = got_fd; rq1 = req_log[67];
    run(1, 32'h0000_0080, 0, -1, 80);
    vecs++; if (n1 !== 1) begin errs++; $display("FAIL b2b nfill1 got %0d exp 1", n1); end
    vecs++; if (fa1 !== 32'h40) begin errs++; $display("FAIL b2b fill_a1 got %h exp 40", fa1); end
    vecs++; if (fd1 !== line(32'h40)) begin errs++; $display("FAIL b2b line1 got %h exp %h", fd1, line(32'h40)); end
    vecs++; if (rq1 !== 1'b0) begin errs++; $display("FAIL b2b req_gap got %b exp 0", rq1); end
    vecs++; if (req_log[1] !== 1'b1) begin errs++; $display("FAIL b2b req2 got %b exp 1", req_log[1]); end
    vecs++; if (nfill !== 1) begin errs++; $display("FAIL b2b nfill2 got %0d exp 1", nfill); end
    vecs++; if (fill_cyc !== 67) begin errs++; $display("FAIL b2b fill_cyc2 got %0d exp 67", fill_cyc); end
    vecs++; if (got_fa !== 32'h80) begin errs++; $display("FAIL b2b fill_a2 got %h exp 80", got_fa); end
    vecs++; if (got_fd !== line(32'h80)) begin errs++; $display("FAIL b2b line2 got %h exp %h", got_fd, line(32'h80)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_grant_delay;
    test_flush;
    test_flush_done;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
